// File: rtl/quad_cmd_pkg.sv
// Shared opcode, response and state definitions for the quad command dispatcher.
package quad_cmd_pkg;

    localparam logic [7:0] OP_SET_PTCH  = 8'h02;
    localparam logic [7:0] OP_SET_ROLL  = 8'h03;
    localparam logic [7:0] OP_SET_YAW   = 8'h04;
    localparam logic [7:0] OP_SET_THRST = 8'h05;
    localparam logic [7:0] OP_CALIBRATE = 8'h06;
    localparam logic [7:0] OP_EMER_LAND = 8'h07;
    localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_CAL  = 2'd1,
        SEND      = 2'd2,
        WAIT_SENT = 2'd3
    } state_t;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op >= OP_SET_PTCH) && (op <= OP_MTRS_OFF);
    endfunction

endpackage

// File: rtl/cmd_wdog.sv
// Command watchdog: counts clocks since the last accepted command and
// saturates, holding tmo high until the next clear.
module cmd_wdog #(
    parameter int FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tmo
);

    localparam int W = (FAST_SIM != 0) ? 9 : 26;
    localparam logic [W-1:0] TC = '1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (cnt != TC)
            cnt <= cnt + 1'b1;
    end

    assign tmo = (cnt == TC);

endmodule

// File: rtl/cmd_dispatch.sv
// Decodes 24-bit UART commands into flight setpoints, sequences calibration
// and returns a one-byte ACK/NAK per command.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for cmd_rdy; decodes in the accept cycle
// WAIT_CAL  | calibration running, waiting for cal_done
// SEND      | one-cycle send_resp pulse
// WAIT_SENT | waiting for resp_sent from the transmitter
module cmd_dispatch #(
    parameter int FAST_SIM = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_rdy,
    input  logic [7:0]         cmd,
    input  logic [15:0]        data,
    output logic               clr_cmd_rdy,
    output logic               send_resp,
    output logic [7:0]         resp,
    input  logic               resp_sent,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    output logic               strt_cal,
    output logic               inertial_cal,
    input  logic               cal_done,
    output logic               motors_off
);
    import quad_cmd_pkg::*;

    state_t state, nxt_state;
    logic   tmo;

    cmd_wdog #(.FAST_SIM(FAST_SIM)) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cmd_rdy),
        .tmo   (tmo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:      if (cmd_rdy) nxt_state = (cmd == OP_CALIBRATE) ? WAIT_CAL : SEND;
            WAIT_CAL:  if (cal_done) nxt_state = SEND;
            SEND:      nxt_state = WAIT_SENT;
            WAIT_SENT: if (resp_sent) nxt_state = IDLE;
            default:   nxt_state = IDLE;
        endcase
    end

    // rst_n gating keeps the acknowledge quiet while reset is held
    always_comb begin
        clr_cmd_rdy = rst_n && (state == IDLE) && cmd_rdy;
        strt_cal    = clr_cmd_rdy && (cmd == OP_CALIBRATE);
        send_resp   = (state == SEND);
    end

    // Timeout zeroing comes first so a same-cycle load overrides it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_ptch       <= '0;
            d_roll       <= '0;
            d_yaw        <= '0;
            thrst        <= '0;
            motors_off   <= 1'b1;
            inertial_cal <= 1'b0;
            resp         <= 8'h00;
        end else begin
            if (tmo) begin
                d_ptch <= '0;
                d_roll <= '0;
                d_yaw  <= '0;
                thrst  <= '0;
            end
            if (clr_cmd_rdy) begin
                resp <= is_known_op(cmd) ? RESP_ACK : RESP_NAK;
                case (cmd)
                    OP_SET_PTCH:  d_ptch <= data;
                    OP_SET_ROLL:  d_roll <= data;
                    OP_SET_YAW:   d_yaw  <= data;
                    OP_SET_THRST: thrst  <= data[8:0];
                    OP_CALIBRATE: begin
                        motors_off   <= 1'b0;
                        inertial_cal <= 1'b1;
                    end
                    OP_EMER_LAND: begin
                        d_ptch <= '0;
                        d_roll <= '0;
                        d_yaw  <= '0;
                        thrst  <= '0;
                    end
                    OP_MTRS_OFF:  motors_off <= 1'b1;
                    default: ;
                endcase
            end
            if ((state == WAIT_CAL) && cal_done)
                inertial_cal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: expected response bytes are queued
// when a command is driven and compared when send_resp fires.
module tb_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_rdy = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        resp_sent = 1'b0;
    logic        cal_done = 1'b0;
    logic        clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off;
    logic [7:0]  resp;
    logic [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]  thrst;

    int n_chk = 0;
    int n_err = 0;
    int n_resp = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n0;
    logic [7:0] exp_q[$];
    logic [7:0] last_exp = 8'h00;

    logic [15:0] m_ptch, m_roll, m_yaw;
    logic [8:0]  m_thrst;
    logic        m_moff;

    cmd_dispatch #(.FAST_SIM(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp),
        .resp_sent    (resp_sent),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .cal_done     (cal_done),
        .motors_off   (motors_off)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One response outstanding at a time, so the queue must hold exactly one
    always @(negedge clk) begin
        if (send_resp) begin
            n_resp++;
            chk("resp_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0)
                chk("resp", resp, exp_q.pop_front());
        end
    end

    task automatic check_regs(input string tag);
        chk({tag, "_ptch"},  d_ptch,     m_ptch);
        chk({tag, "_roll"},  d_roll,     m_roll);
        chk({tag, "_yaw"},   d_yaw,      m_yaw);
        chk({tag, "_thrst"}, thrst,      m_thrst);
        chk({tag, "_moff"},  motors_off, m_moff);
    endtask

    task automatic model_reset();
        m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; m_moff = 1'b1;
    endtask

    task automatic check_reset_outs(input string tag);
        check_regs(tag);
        chk({tag, "_resp"},  resp,         8'h00);
        chk({tag, "_ical"},  inertial_cal, 1'b0);
        chk({tag, "_scal"},  strt_cal,     1'b0);
        chk({tag, "_clr"},   clr_cmd_rdy,  1'b0);
        chk({tag, "_send"},  send_resp,    1'b0);
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] dat);
        int k;
        @(negedge clk);
        cmd = op; data = dat; cmd_rdy = 1'b1;
        last_exp = (op >= 8'h02 && op <= 8'h08) ? 8'hA5 : 8'hEE;
        exp_q.push_back(last_exp);
        k = 0;
        #1;
        while (!clr_cmd_rdy && k < 50) begin
            @(negedge clk); #1; k++;
        end
        chk("clr_cmd_rdy_hi", clr_cmd_rdy, 1'b1);
        chk("strt_cal_decode", strt_cal, op == 8'h06);
        @(posedge clk);
        acc_cyc = cyc;
        #1 cmd_rdy = 1'b0;
        chk("clr_cmd_rdy_pulse", clr_cmd_rdy, 1'b0);
    endtask

    task automatic wait_send();
        int k;
        k = 0;
        while (!send_resp && k < 100) begin
            @(negedge clk); #1; k++;
        end
        chk("send_resp_seen", send_resp, 1'b1);
    endtask

    task automatic ack();
        @(posedge clk); #1;
        chk("send_resp_1cyc", send_resp, 1'b0);
        chk("resp_held", resp, last_exp);
        @(negedge clk) resp_sent = 1'b1;
        @(negedge clk) resp_sent = 1'b0;
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [15:0] dat);
        issue(op, dat);
        wait_send();
        ack();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_outs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Pitch load visible the cycle after decode
        issue(8'h02, 16'h1234);
        m_ptch = 16'h1234;
        chk("ptch_next_cycle", d_ptch, 16'h1234);
        wait_send();
        ack();
        #1 check_regs("set_ptch");

        // cmd_rdy raised in WAIT_SENT is held off until IDLE
        issue(8'h03, 16'hBEEF);
        m_roll = 16'hBEEF;
        wait_send();
        @(posedge clk); #1;
        cmd = 8'h04; data = 16'h0042; cmd_rdy = 1'b1;
        exp_q.push_back(8'hA5);
        chk("pending_ignored", clr_cmd_rdy, 1'b0);
        chk("pending_resp_held", resp, 8'hA5);
        @(negedge clk) resp_sent = 1'b1;
        @(negedge clk) resp_sent = 1'b0;
        #1 chk("pending_serviced", clr_cmd_rdy, 1'b1);
        @(posedge clk); #1 cmd_rdy = 1'b0;
        last_exp = 8'hA5;
        m_yaw = 16'h0042;
        wait_send();
        ack();
        #1 check_regs("roll_yaw");

        do_cmd(8'h05, 16'hFFFF);
        m_thrst = 9'h1FF;
        check_regs("thrst_ffff");

        // Calibration holds off the response until cal_done
        issue(8'h06, 16'h0000);
        m_moff = 1'b0;
        chk("cal_strt_done", strt_cal, 1'b0);
        chk("cal_ical_hi", inertial_cal, 1'b1);
        chk("cal_moff", motors_off, 1'b0);
        n0 = n_resp;
        repeat (10) @(negedge clk);
        #1 chk("cal_no_resp", 32'(n_resp), 32'(n0));
        chk("cal_ical_held", inertial_cal, 1'b1);
        @(negedge clk) cal_done = 1'b1;
        @(negedge clk) cal_done = 1'b0;
        #1 chk("cal_ical_lo", inertial_cal, 1'b0);
        wait_send();
        ack();
        #1 check_regs("calibrate");

        do_cmd(8'h3C, 16'hFFFF);
        check_regs("bad_op");

        do_cmd(8'h08, 16'h0000);
        m_moff = 1'b1;
        check_regs("mtrs_off");

        do_cmd(8'h07, 16'h0000);
        m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0;
        check_regs("emer_land");

        // Watchdog: silence after the thrust load zeroes the setpoints
        do_cmd(8'h02, 16'h0321);
        m_ptch = 16'h0321;
        do_cmd(8'h05, 16'h0100);
        m_thrst = 9'h100;
        while (cyc < acc_cyc + 500) @(negedge clk);
        #1 check_regs("wdog_before");
        while (cyc < acc_cyc + 520) @(negedge clk);
        m_ptch = 0; m_thrst = 0;
        #1 check_regs("wdog_after");
        do_cmd(8'h05, 16'h0050);
        m_thrst = 9'h050;
        check_regs("wdog_reload");

        // Reset while waiting for resp_sent
        issue(8'h03, 16'h0777);
        wait_send();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 model_reset();
        check_reset_outs("mid_reset");
        n0 = n_resp;
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1 chk("no_resp_after_rst", 32'(n_resp), 32'(n0));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        do_cmd(8'h04, 16'h8001);
        m_yaw = 16'h8001;
        check_regs("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1; 1 selects the short watchdog timeout for simulation.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cmd_rdy, input, 1, a complete 24-bit command is available from the UART command receiver.
REQ-005 SHALL have port cmd, input, 8, command opcode.
REQ-006 SHALL have port data, input, 16, command parameter.
REQ-007 SHALL have port clr_cmd_rdy, output, 1, one-cycle pulse acknowledging that the command was consumed.
REQ-008 SHALL have port send_resp, output, 1, one-cycle pulse that starts transmission of a response byte.
REQ-009 SHALL have port resp, output, 8, response byte.
REQ-010 SHALL have port resp_sent, input, 1, response transmission complete.
REQ-011 SHALL have ports d_ptch, d_roll, d_yaw, output, 16 each, signed pitch/roll/yaw setpoints.
REQ-012 SHALL have port thrst, output, 9, thrust setpoint.
REQ-013 SHALL have port strt_cal, output, 1, one-cycle calibration start pulse.
REQ-014 SHALL have port inertial_cal, output, 1, high while calibration is in progress.
REQ-015 SHALL have port cal_done, input, 1, calibration complete.
REQ-016 SHALL have port motors_off, output, 1, motor disable.

Function
REQ-017 SHALL use these opcodes: 0x02 SET_PTCH, 0x03 SET_ROLL, 0x04 SET_YAW, 0x05 SET_THRST, 0x06 CALIBRATE, 0x07 EMER_LAND, 0x08 MTRS_OFF.
REQ-018 SHALL implement the states IDLE, WAIT_CAL, SEND and WAIT_SENT.
REQ-019 SHALL, in IDLE with cmd_rdy=1, pulse clr_cmd_rdy for exactly one cycle and decode cmd in that same cycle.
REQ-020 SHALL, for SET_PTCH, SET_ROLL and SET_YAW, load data into the matching register on the decode clock edge and go to SEND.
REQ-021 SHALL, for SET_THRST, load data[8:0] into thrst and go to SEND.
REQ-022 SHALL, for CALIBRATE, clear motors_off, pulse strt_cal, set inertial_cal, and go to WAIT_CAL.
REQ-023 SHALL, in WAIT_CAL, hold inertial_cal high and sample cal_done only in that state; on cal_done=1, clear inertial_cal and go to SEND.
REQ-024 SHALL, for EMER_LAND, zero d_ptch, d_roll, d_yaw and thrst and go to SEND.
REQ-025 SHALL, for MTRS_OFF, set motors_off and go to SEND.
REQ-026 SHALL, for an undefined opcode, leave all registers unchanged and go to SEND with resp=0xEE.
REQ-027 SHALL otherwise use resp=0xA5 (ACK).
REQ-028 SHALL hold resp stable from SEND until WAIT_SENT exits.
REQ-029 SHALL, in SEND, pulse send_resp for one cycle and go to WAIT_SENT.
REQ-030 SHALL, in WAIT_SENT, return to IDLE on resp_sent=1.
REQ-031 SHALL ignore cmd_rdy outside IDLE; a pending cmd_rdy is serviced in the first IDLE cycle, giving a minimum of 1 idle cycle between commands.
REQ-032 SHALL run a watchdog that counts clocks, clears on every accepted command, and saturates at terminal count 2^26-1 (FAST_SIM=1: 2^9-1).
REQ-033 SHALL, while the watchdog is at terminal count, force d_ptch, d_roll, d_yaw and thrst to 0 each cycle without changing state; calibration and response handshakes continue.
REQ-034 SHALL give the watchdog zero priority over a SET_* load in the same cycle, because acceptance clears the watchdog first.

Reset
REQ-035 SHALL, on rst_n=0, asynchronously force: state=IDLE, d_ptch/d_roll/d_yaw/thrst=0, motors_off=1, inertial_cal=0, strt_cal=0, clr_cmd_rdy=0, send_resp=0, resp=0x00, watchdog=0.
REQ-036 SHALL, on reset mid-operation (WAIT_CAL or WAIT_SENT), abandon the in-flight handshake and emit no response after reset release.

Structure
REQ-037 SHALL place the opcode constants, the 0xA5/0xEE response constants and the state enum in shared package quad_cmd_pkg.
REQ-038 SHALL implement the watchdog as sub-module cmd_wdog, with ports clk, rst_n, clr, FAST_SIM parameter, and tmo output.

Verification
REQ-039 SHALL cover: cmd=0x02, data=0x1234, cmd_rdy -> clr_cmd_rdy 1 cycle, d_ptch=0x1234 next cycle, send_resp with resp=0xA5, IDLE after resp_sent.
REQ-040 SHALL cover: cmd=0x05, data=0xFFFF -> thrst=0x1FF.
REQ-041 SHALL cover: cmd=0x06 -> strt_cal 1 cycle, motors_off=0, inertial_cal high, no send_resp until cal_done, then resp=0xA5.
REQ-042 SHALL cover: cmd=0x3C -> resp=0xEE and all setpoints unchanged.
REQ-043 SHALL cover: FAST_SIM=1, thrst=0x100, then no command for 512 cycles -> thrst=0, d_*=0; next SET_THRST 0x050 -> thrst=0x050.
REQ-044 SHALL cover: rst_n asserted in WAIT_SENT -> all outputs at reset values immediately, no send_resp after release.
